// File: rtl/sha256_msg_sched.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_sched
// Description : SHA-256 message scheduler. Accepts one 512-bit message block
//               and streams the 64 round words W[t] together with the round
//               constants K[t] to the round datapath, one pair per beat.
//               W[t] comes from a 16-word sliding window that produces
//               W[t+16] on every transfer.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               blk_valid  - blk_data holds a block to schedule
//               blk_ready  - idle, a block is accepted this cycle
//               blk_data   - big-endian block, M[0] = bits 511:480
//               w_valid    - w_o/k_o/t_o hold a valid round beat
//               w_ready    - consumer takes the current beat
//               w_o        - W[t]
//               k_o        - K[t]
//               t_o        - round index t
//               last_o     - current beat is round 63
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_o,
    output logic [31:0]  k_o,
    output logic [5:0]   t_o,
    output logic         last_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0] C_K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [5:0] C_LAST_ROUND = 6'd63;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [5:0]        r_t;
    logic [31:0]       r_win [16];
    logic [15:0][31:0] w_blk_words;
    logic [31:0]       w_next_word;
    logic              w_accept;
    logic              w_xfer;
    logic              w_last;

    // Packed view of the block: word 15 of the packed vector is M[0].
    assign w_blk_words = blk_data;

    // W[t+16] from the window that currently holds W[t..t+15]. Words past
    // W[63] are produced in the last rounds but never emitted.
    assign w_next_word = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

    always_comb begin
        w_state_nxt = r_state;
        blk_ready   = 1'b0;
        w_valid     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_valid = 1'b1;
                w_last  = (r_t == C_LAST_ROUND);
                if (w_ready && w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = blk_valid & blk_ready;
    assign w_xfer   = w_valid & w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t <= 6'd0;
        end else if (w_accept) begin
            r_t <= 6'd0;
        end else if (w_xfer) begin
            // Explicit return to 0 after round 63 rather than relying on wrap.
            r_t <= w_last ? 6'd0 : r_t + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= 32'd0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= w_blk_words[15 - i];
            end
        end else if (w_xfer) begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i + 1];
            end
            r_win[15] <= w_next_word;
        end
    end

    assign w_o    = r_win[0];
    assign k_o    = C_K_ROM[r_t];
    assign t_o    = r_t;
    assign last_o = w_last;

endmodule
`default_nettype wire
